// File: rtl/frame_sink.sv
// frame_sink: buffers processor pixel writes in a small FIFO and drains them
// into the result frame RAM over a ready/valid handshake, counting stored pixels.
module frame_sink #(
    parameter int unsigned WidthAddressSize  = 6,
    parameter int unsigned HeightAddressSize = 6,
    parameter int unsigned Resolution        = 8,
    parameter int unsigned FifoDepthLog2     = 2
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        ce,
    input  logic                                        clearFrame,
    input  logic                                        writePixel,
    input  logic [3*Resolution-1:0]                     outputPixel,
    input  logic [HeightAddressSize-1:0]                outputLine,
    input  logic [WidthAddressSize-1:0]                 outputColumn,
    output logic                                        full,
    output logic                                        memWe,
    input  logic                                        memReady,
    output logic [WidthAddressSize+HeightAddressSize-1:0] memAddr,
    output logic [3*Resolution-1:0]                     memData,
    output logic [WidthAddressSize+HeightAddressSize:0] pixelCount,
    output logic                                        frameDone,
    output logic                                        overflow
);

    localparam int unsigned PixelBits  = 3 * Resolution;
    localparam int unsigned AddrBits   = WidthAddressSize + HeightAddressSize;
    localparam int unsigned EntryBits  = AddrBits + PixelBits;
    localparam int unsigned FifoDepth  = 1 << FifoDepthLog2;
    localparam int unsigned OccBits    = FifoDepthLog2 + 1;
    localparam int unsigned CountBits  = AddrBits + 1;
    localparam int unsigned FrameSize  = 1 << AddrBits;

    logic [EntryBits-1:0]     fifoMem [FifoDepth];
    logic [FifoDepthLog2-1:0] headPtr;
    logic [FifoDepthLog2-1:0] tailPtr;
    logic [OccBits-1:0]       occupancy;
    logic [OccBits-1:0]       occupancyNext;
    logic                     stageValid;

    logic fifoEmpty;
    logic pushEn;
    logic dropEn;
    logic transferEn;
    logic loadEn;

    // Handshake decode: full comes from current occupancy only, so a pop never unblocks a push.
    always_comb begin
        fifoEmpty     = (occupancy == '0);
        pushEn        = writePixel & ce & ~full;
        dropEn        = writePixel & ce & full;
        transferEn    = stageValid & ce & memReady;
        loadEn        = ce & ~fifoEmpty & (~stageValid | transferEn);
        memWe         = stageValid & ce;
        occupancyNext = occupancy;
        case ({pushEn, loadEn})
            2'b10:   occupancyNext = occupancy + OccBits'(1);
            2'b01:   occupancyNext = occupancy - OccBits'(1);
            default: occupancyNext = occupancy;
        endcase
    end

    // FIFO storage; contents are don't-care while pointers say empty.
    always_ff @(posedge clk) begin
        if (pushEn) begin
            fifoMem[tailPtr] <= {outputLine, outputColumn, outputPixel};
        end
    end

    // FIFO pointers, occupancy and the registered full flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            headPtr   <= '0;
            tailPtr   <= '0;
            occupancy <= '0;
            full      <= 1'b0;
        end else begin
            if (pushEn) tailPtr <= tailPtr + FifoDepthLog2'(1);
            if (loadEn) headPtr <= headPtr + FifoDepthLog2'(1);
            occupancy <= occupancyNext;
            full      <= (occupancyNext == OccBits'(FifoDepth));
        end
    end

    // Output stage: holds address/data stable until the RAM accepts them.
    always_ff @(posedge clk) begin
        if (rst) begin
            stageValid <= 1'b0;
            memAddr    <= '0;
            memData    <= '0;
        end else if (loadEn) begin
            stageValid         <= 1'b1;
            {memAddr, memData} <= fifoMem[headPtr];
        end else if (transferEn) begin
            stageValid <= 1'b0;
        end
    end

    // Completed-write counter, saturating at one full frame; clear beats a same-edge transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            pixelCount <= '0;
            frameDone  <= 1'b0;
        end else if (ce) begin
            if (clearFrame) begin
                pixelCount <= '0;
                frameDone  <= 1'b0;
            end else if (transferEn && (pixelCount != CountBits'(FrameSize))) begin
                pixelCount <= pixelCount + CountBits'(1);
                if (pixelCount == CountBits'(FrameSize - 1)) frameDone <= 1'b1;
            end
        end
    end

    // Sticky flag for strobes lost while the FIFO was full.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (dropEn) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_frame_sink.sv
// tb_frame_sink: directed scenario tests for frame_sink with a write-log monitor.
module tb_frame_sink;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic        clearFrame;
    logic        writePixel;
    logic [23:0] outputPixel;
    logic [5:0]  outputLine;
    logic [5:0]  outputColumn;
    logic        full;
    logic        memWe;
    logic        memReady;
    logic [11:0] memAddr;
    logic [23:0] memData;
    logic [12:0] pixelCount;
    logic        frameDone;
    logic        overflow;

    int tests  = 0;
    int failed = 0;

    logic [35:0] wrQ[$];
    int          hits [4096];
    logic [23:0] lastData [4096];

    frame_sink dut (
        .clk(clk), .rst(rst), .ce(ce), .clearFrame(clearFrame),
        .writePixel(writePixel), .outputPixel(outputPixel),
        .outputLine(outputLine), .outputColumn(outputColumn),
        .full(full), .memWe(memWe), .memReady(memReady),
        .memAddr(memAddr), .memData(memData),
        .pixelCount(pixelCount), .frameDone(frameDone), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Log every accepted RAM write as {addr, data}.
    always @(posedge clk) begin
        if (memWe && memReady) wrQ.push_back({memAddr, memData});
    end

    function automatic logic [35:0] mkEntry(input int i);
        logic [5:0]  ln;
        logic [5:0]  col;
        logic [23:0] px;
        ln  = 6'(2 + i);
        col = 6'(5 + i);
        px  = 24'hA1B2C3 + 24'(i);
        return {ln, col, px};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [35:0] e, input logic wp);
        {outputLine, outputColumn, outputPixel} = e;
        writePixel = wp;
    endtask

    task automatic doRst();
        rst = 1'b1; ce = 1'b1; clearFrame = 1'b0; memReady = 1'b0;
        drive(36'h0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        doRst();
        tests++; if (full !== 1'b0) begin failed++; $display("FAIL reset_full: got %0b expected 0", full); end
        tests++; if (memWe !== 1'b0) begin failed++; $display("FAIL reset_memWe: got %0b expected 0", memWe); end
        tests++; if (memAddr !== 12'h0) begin failed++; $display("FAIL reset_memAddr: got %0h expected 0", memAddr); end
        tests++; if (memData !== 24'h0) begin failed++; $display("FAIL reset_memData: got %0h expected 0", memData); end
        tests++; if (pixelCount !== 13'd0) begin failed++; $display("FAIL reset_pixelCount: got %0d expected 0", pixelCount); end
        tests++; if (frameDone !== 1'b0) begin failed++; $display("FAIL reset_frameDone: got %0b expected 0", frameDone); end
        tests++; if (overflow !== 1'b0) begin failed++; $display("FAIL reset_overflow: got %0b expected 0", overflow); end
    endtask

    task automatic test_streaming();
        int base;
        logic [35:0] e;
        doRst();
        base = wrQ.size();
        memReady = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(mkEntry(i), 1'b1);
            tick();
            if (i == 0) begin
                tests++; if (memWe !== 1'b0) begin failed++; $display("FAIL stream_latency0: got memWe=%0b expected 0", memWe); end
            end else begin
                e = mkEntry(i - 1);
                tests++; if (memWe !== 1'b1 || memAddr !== e[35:24]) begin failed++; $display("FAIL stream_cycle%0d: got memWe=%0b addr=%0h expected 1 addr=%0h", i, memWe, memAddr, e[35:24]); end
            end
        end
        drive(36'h0, 1'b0);
        tick();
        e = mkEntry(5);
        tests++; if (memWe !== 1'b1 || memAddr !== e[35:24]) begin failed++; $display("FAIL stream_last: got memWe=%0b addr=%0h expected 1 addr=%0h", memWe, memAddr, e[35:24]); end
        tick();
        tests++; if (memWe !== 1'b0) begin failed++; $display("FAIL stream_idle: got memWe=%0b expected 0", memWe); end
        tests++; if (wrQ.size() - base != 6) begin failed++; $display("FAIL stream_writes: got %0d expected 6", wrQ.size() - base); end
        for (int i = 0; i < 6 && base + i < wrQ.size(); i++) begin
            tests++; if (wrQ[base + i] !== mkEntry(i)) begin failed++; $display("FAIL stream_order%0d: got %0h expected %0h", i, wrQ[base + i], mkEntry(i)); end
        end
        tests++; if (pixelCount !== 13'd6) begin failed++; $display("FAIL stream_count: got %0d expected 6", pixelCount); end
    endtask

    task automatic test_reset_mid_drain();
        int base;
        memReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(mkEntry(20 + i), 1'b1);
            tick();
        end
        drive(36'h0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        base = wrQ.size();
        tests++; if (memWe !== 1'b0) begin failed++; $display("FAIL middrain_memWe: got %0b expected 0", memWe); end
        tests++; if (full !== 1'b0) begin failed++; $display("FAIL middrain_full: got %0b expected 0", full); end
        tests++; if (pixelCount !== 13'd0) begin failed++; $display("FAIL middrain_count: got %0d expected 0", pixelCount); end
        tests++; if (overflow !== 1'b0) begin failed++; $display("FAIL middrain_overflow: got %0b expected 0", overflow); end
        memReady = 1'b1;
        repeat (5) tick();
        tests++; if (wrQ.size() != base) begin failed++; $display("FAIL middrain_stale: got %0d writes expected 0", wrQ.size() - base); end
    endtask

    // Stage absorbs the first entry, so the 4-deep FIFO fills on the 5th back-to-back push.
    task automatic test_backpressure();
        int base;
        doRst();
        base = wrQ.size();
        for (int i = 0; i < 6; i++) begin
            drive(mkEntry(30 + i), 1'b1);
            tick();
            if (i == 3) begin
                tests++; if (full !== 1'b0) begin failed++; $display("FAIL bp_full_early: got %0b expected 0", full); end
            end
            if (i == 4) begin
                tests++; if (full !== 1'b1) begin failed++; $display("FAIL bp_full: got %0b expected 1", full); end
                tests++; if (overflow !== 1'b0) begin failed++; $display("FAIL bp_overflow_early: got %0b expected 0", overflow); end
            end
        end
        tests++; if (overflow !== 1'b1) begin failed++; $display("FAIL bp_overflow: got %0b expected 1", overflow); end
        drive(36'h0, 1'b0);
        memReady = 1'b1;
        repeat (8) tick();
        tests++; if (wrQ.size() - base != 5) begin failed++; $display("FAIL bp_writes: got %0d expected 5", wrQ.size() - base); end
        for (int i = 0; i < 5 && base + i < wrQ.size(); i++) begin
            tests++; if (wrQ[base + i] !== mkEntry(30 + i)) begin failed++; $display("FAIL bp_order%0d: got %0h expected %0h", i, wrQ[base + i], mkEntry(30 + i)); end
        end
        tests++; if (pixelCount !== 13'd5) begin failed++; $display("FAIL bp_count: got %0d expected 5", pixelCount); end
        tests++; if (overflow !== 1'b1 || full !== 1'b0) begin failed++; $display("FAIL bp_final: got overflow=%0b full=%0b expected 1 0", overflow, full); end
    endtask

    task automatic test_ce();
        int base;
        logic [35:0] e;
        doRst();
        base = wrQ.size();
        for (int i = 0; i < 2; i++) begin
            drive(mkEntry(40 + i), 1'b1);
            tick();
        end
        drive(36'h0, 1'b0);
        tick();
        tests++; if (memWe !== 1'b1) begin failed++; $display("FAIL ce_pre: got memWe=%0b expected 1", memWe); end
        ce = 1'b0;
        memReady = 1'b1;
        drive(mkEntry(50), 1'b1);
        #1;
        for (int c = 0; c < 5; c++) begin
            tests++; if (memWe !== 1'b0 || wrQ.size() != base || pixelCount !== 13'd0) begin failed++; $display("FAIL ce_frozen%0d: got memWe=%0b writes=%0d count=%0d expected 0 0 0", c, memWe, wrQ.size() - base, pixelCount); end
            tick();
        end
        ce = 1'b1;
        drive(36'h0, 1'b0);
        #1;
        e = mkEntry(40);
        tests++; if (memWe !== 1'b1 || memAddr !== e[35:24]) begin failed++; $display("FAIL ce_resume: got memWe=%0b addr=%0h expected 1 addr=%0h", memWe, memAddr, e[35:24]); end
        repeat (4) tick();
        tests++; if (wrQ.size() - base != 2) begin failed++; $display("FAIL ce_writes: got %0d expected 2", wrQ.size() - base); end
        tests++; if (pixelCount !== 13'd2 || overflow !== 1'b0) begin failed++; $display("FAIL ce_count: got count=%0d overflow=%0b expected 2 0", pixelCount, overflow); end
    endtask

    task automatic test_clear_coincident();
        int base;
        doRst();
        base = wrQ.size();
        memReady = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(mkEntry(60 + i), 1'b1);
            tick();
        end
        drive(36'h0, 1'b0);
        repeat (4) tick();
        tests++; if (pixelCount !== 13'd10) begin failed++; $display("FAIL clr_pre: got %0d expected 10", pixelCount); end
        memReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(mkEntry(70 + i), 1'b1);
            tick();
        end
        drive(36'h0, 1'b0);
        tick();
        memReady = 1'b1;
        clearFrame = 1'b1;
        tick();
        clearFrame = 1'b0;
        tests++; if (pixelCount !== 13'd0 || frameDone !== 1'b0) begin failed++; $display("FAIL clr_edge: got count=%0d done=%0b expected 0 0", pixelCount, frameDone); end
        repeat (3) tick();
        tests++; if (pixelCount !== 13'd2) begin failed++; $display("FAIL clr_after: got %0d expected 2", pixelCount); end
        tests++; if (wrQ.size() - base != 13) begin failed++; $display("FAIL clr_writes: got %0d expected 13", wrQ.size() - base); end
        for (int i = 0; i < 3 && base + 10 + i < wrQ.size(); i++) begin
            tests++; if (wrQ[base + 10 + i] !== mkEntry(70 + i)) begin failed++; $display("FAIL clr_order%0d: got %0h expected %0h", i, wrQ[base + 10 + i], mkEntry(70 + i)); end
        end
    endtask

    task automatic test_full_frame();
        int base;
        int idx;
        int bad;
        bit seenDone;
        logic [11:0] a;
        logic [23:0] px;
        doRst();
        base = wrQ.size();
        idx = 0;
        seenDone = 1'b0;
        for (int c = 0; c < 30000 && !(seenDone && idx == 4096); c++) begin
            if (idx < 4096 && !full) begin
                a  = 12'(idx);
                px = 24'(idx * 7 + 3) ^ 24'h5A5A5A;
                drive({a, px}, 1'b1);
                idx++;
            end else begin
                drive(36'h0, 1'b0);
            end
            memReady = 1'($urandom_range(0, 1));
            tick();
            if (!seenDone && frameDone) begin
                seenDone = 1'b1;
                tests++; if (wrQ.size() - base != 4096 || pixelCount !== 13'd4096) begin failed++; $display("FAIL frame_done_edge: got writes=%0d count=%0d expected 4096 4096", wrQ.size() - base, pixelCount); end
            end
        end
        tests++; if (!seenDone) begin failed++; $display("FAIL frame_timeout: got frameDone=0 pushed=%0d expected frameDone=1", idx); end
        for (int i = 0; i < 4096; i++) hits[i] = 0;
        for (int i = base; i < wrQ.size(); i++) begin
            a = wrQ[i][35:24];
            hits[a]++;
            lastData[a] = wrQ[i][23:0];
        end
        bad = 0;
        for (int i = 0; i < 4096; i++) begin
            px = 24'(i * 7 + 3) ^ 24'h5A5A5A;
            if (hits[i] != 1 || lastData[i] !== px) bad++;
        end
        tests++; if (bad != 0) begin failed++; $display("FAIL frame_locations: got %0d bad locations expected 0", bad); end
        memReady = 1'b1;
        drive({12'h000, 24'h111111}, 1'b1);
        tick();
        drive({12'h001, 24'h222222}, 1'b1);
        tick();
        drive(36'h0, 1'b0);
        repeat (4) tick();
        tests++; if (wrQ.size() - base != 4098) begin failed++; $display("FAIL frame_extra_writes: got %0d expected 4098", wrQ.size() - base); end
        tests++; if (pixelCount !== 13'd4096 || frameDone !== 1'b1) begin failed++; $display("FAIL frame_saturate: got count=%0d done=%0b expected 4096 1", pixelCount, frameDone); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_reset_mid_drain();
        test_backpressure();
        test_ce();
        test_clear_coincident();
        test_full_frame();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
